sram_ctrl: RTL
==============

# sram_ctrl

Request-side controller for the single-port `sram` macro. It accepts read/write requests on a valid/ready interface and drives the macro's A/D/WEN pins. It captures the macro's one-cycle-late Q output into a 2-entry response buffer, which it presents on a valid/ready response interface. It sits between any pipeline client (fetch, LSU, DMA) and an `sram` instance, and absorbs response backpressure without losing read data.

## Interface
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width.
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready; a request fires when req_vld && req_rdy.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH/8  byte write enables; ignored for reads.
- rsp_vld  out  1  read data valid.
- rsp_rdy  in  1  response consumer ready.
- rsp_rdata  out  DATA_WIDTH  read data.
- A  out  ADDR_WIDTH  to sram A.
- D  out  DATA_WIDTH  to sram D.
- WEN  out  DATA_WIDTH  to sram WEN; per-bit write enable, active-high.
- Q  in  DATA_WIDTH  from sram Q; valid exactly one cycle after a read is issued.

## Operation
- Reset is asynchronous and active-low. While RSTN=0 or after reset: rsp_vld=0, response buffer empty, inflight=0, req_rdy=0 (forced low while RSTN=0), WEN=0.
- A and D are combinational pass-throughs of req_addr and req_wdata.
- WEN is nonzero only on a write fire. On a write fire, WEN = req_wmask with each bit expanded ×8. On a read fire or no fire, WEN = 0.
- Writes produce no response. A write always fires when req_vld=1, because it needs no buffer slot.
- A read fire sets `inflight` for the next cycle. In that cycle Q is pushed into the response buffer unconditionally. Q is not held by the macro, so the capture cycle must not be missed.
- Reads are accepted when occ + inflight − pop < 2, where occ is the buffer occupancy (0..2) and pop = rsp_vld && rsp_rdy. req_rdy therefore depends combinationally on rsp_rdy. This dependency is intentional and allows 1 read/cycle throughput.
- The response buffer is a 2-entry FIFO. rsp_vld = (occ != 0), and rsp_rdata is the head entry, driven from a register.
- Simultaneous push and pop leaves occ unchanged. Push when occ=2 is impossible by construction; add an assertion for it.
- Ordering: responses return in read-issue order. A read issued the cycle after a write to the same address returns the new data. One operation per cycle means there is no same-cycle read/write collision.
- RSTN asserted mid-operation: the in-flight read and all buffered responses are discarded, and no response is emitted for them.

## Timing
- Read latency with rsp_rdy=1: fire at cycle t, Q captured at the t+1 edge, rsp_vld=1 during t+2. Request-to-response latency is therefore 2 cycles.
- Throughput: 1 request/cycle sustained (reads, writes, or a mix) while rsp_rdy=1.
- Stalled consumer (rsp_rdy=0): at most 2 reads are outstanding (buffered + inflight). After that req_rdy=0 for reads, while writes still fire.
- rsp_vld/rsp_rdata are stable while rsp_vld && !rsp_rdy.
- Write takes effect in the macro at the fire edge.

## Structure
- Shared package `sram_ctrl_pkg`: RSP_DEPTH=2 constant; a helper function expanding a byte mask to a bit mask.
- One sub-module: `sram_ctrl_rsp_fifo`, a parameterised 2-entry FIFO with push/pop/occ. It is reused by the top module.
- The top module contains only the fire logic, the inflight flop, and WEN expansion. Target size is about 150–250 lines total.

## Test plan
- Reset: hold RSTN=0 with req_vld=1 and req_wr=1 → WEN=0, req_rdy=0, rsp_vld=0. Release RSTN → first request fires next cycle.
- Write 0xDEADBEEF to addr 5 with wmask=4'b1111, then read addr 5 the following cycle → rsp_rdata=0xDEADBEEF, rsp_vld rises 2 cycles after the read fires.
- Byte mask: write 0x11223344 to addr 7, then write 0xAABBCCDD with wmask=4'b0101, then read → 0x11BB33DD.
- Back-to-back reads of addr 0..15 with rsp_rdy=1 → 16 responses on consecutive cycles, in order, with req_rdy never low.
- Backpressure: rsp_rdy=0 while issuing reads to addr 1, 2, 3 → only 2 fire, req_rdy=0 for the third. A write issued during the stall still fires. Raising rsp_rdy drains addr 1, then 2, then the third read proceeds; data matches and order is preserved.
- Reset mid-stream: 2 reads outstanding, pulse RSTN low for 1 cycle → rsp_vld=0 immediately and no stale responses appear after release.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and helpers for the sram request/response controller.
package sram_ctrl_pkg;

   // Response buffer depth: one slot for the capture in progress, one for the stalled head.
   localparam int unsigned RSP_DEPTH = 2;
   localparam int unsigned RSP_OCC_W = $clog2(RSP_DEPTH + 1);

   // Expand one byte-enable into the eight bit-enables of its byte lane.
   function automatic logic [7:0] expand_byte(input logic byte_en);
      return {8{byte_en}};
   endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Small registered FIFO holding read responses captured from the sram Q pins.
module sram_ctrl_rsp_fifo
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = RSP_DEPTH
) (
   input  logic                         CLK,
   input  logic                         RSTN,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         vld,
   output logic [$clog2(DEPTH+1)-1:0]   occ
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             pop_eff;

   // Popping an empty buffer is a no-op.
   assign pop_eff = pop & (occ_q != '0);

   // Pointer wrap and occupancy bookkeeping.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_eff) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop_eff})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Pointer and occupancy state; reset empties the buffer.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage; cleared on reset so the head never shows stale data.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign vld   = (occ_q != '0);
   assign occ   = occ_q;

   // The controller only issues a read when a slot is guaranteed for its capture.
   a_no_push_full : assert property (@(posedge CLK) disable iff (!RSTN)
      push |-> (occ_q < OCC_W'(DEPTH)));

endmodule

// File: rtl/sram_ctrl.sv
// Request-side controller for a single-port sram macro with a buffered read response path.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,  // multiple of 8
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic                    req_vld,
   output logic                    req_rdy,
   input  logic                    req_wr,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wmask,
   output logic                    rsp_vld,
   input  logic                    rsp_rdy,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [ADDR_WIDTH-1:0]   A,
   output logic [DATA_WIDTH-1:0]   D,
   output logic [DATA_WIDTH-1:0]   WEN,
   input  logic [DATA_WIDTH-1:0]   Q
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned UW     = RSP_OCC_W + 1;

   logic                  inflight_q;
   logic                  read_fire;
   logic                  write_fire;
   logic                  pop;
   logic                  read_ok;
   logic [RSP_OCC_W-1:0]  occ;
   logic [UW-1:0]         used;
   logic [DATA_WIDTH-1:0] wen_lanes;

   assign A = req_addr;
   assign D = req_wdata;

   // A read may issue only if its capture next cycle is sure to find a free slot,
   // counting the slot freed by a pop this cycle (keeps 1 read/cycle with rsp_rdy=1).
   assign pop     = rsp_vld & rsp_rdy;
   assign used    = UW'(occ) + UW'(inflight_q);
   assign read_ok = used < (UW'(RSP_DEPTH) + UW'(pop));

   // Writes need no buffer slot; nothing is accepted while reset is asserted.
   assign req_rdy    = RSTN & (req_wr | read_ok);
   assign write_fire = req_vld & req_rdy & req_wr;
   assign read_fire  = req_vld & req_rdy & ~req_wr;

   for (genvar g = 0; g < int'(NBYTES); g++) begin : g_lane
      assign wen_lanes[g*8 +: 8] = expand_byte(req_wmask[g]);
   end

   assign WEN = write_fire ? wen_lanes : '0;

   // Marks the cycle in which the macro presents Q for the read issued last cycle.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= read_fire;
      end
   end

   // Q is not held by the macro, so it is pushed unconditionally in the capture cycle.
   sram_ctrl_rsp_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .push  (inflight_q),
      .wdata (Q),
      .pop   (pop),
      .rdata (rsp_rdata),
      .vld   (rsp_vld),
      .occ   (occ)
   );

endmodule
